// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// stalling the pipeline until every request of the current pipeline cycle is served.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              pipe_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              if_served_q, if_served_d;
  logic              d_served_q, d_served_d;
  logic              err_q, err_d;
  logic              d_act;
  logic              timeout_hit;

  assign d_act       = d_rd | d_wr;
  assign pipe_stall  = (if_req & ~if_served_q & ~if_done_q) |
                       (d_act & ~d_served_q & ~d_done_q);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_served_d = if_served_q;
    d_served_d  = d_served_q;
    err_d       = err_q;

    if (!pipe_stall) begin
      if_served_d = 1'b0;
      d_served_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Data wins: it belongs to the older instruction in the pipe.
        if (d_act && !d_served_q) begin
          state_d     = D_BUSY;
          cnt_d       = '0;
          mem_addr_d  = d_addr;
          mem_we_d    = d_wr;
          mem_wdata_d = d_wdata;
          if (d_rd && d_wr) err_d = 1'b1;
        end else if (if_req && !if_served_q) begin
          state_d     = IF_BUSY;
          cnt_d       = '0;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ready || timeout_hit) begin
          state_d = IDLE;
          if (state_q == IF_BUSY) begin
            if_done_d   = 1'b1;
            if_served_d = 1'b1;
          end else begin
            d_done_d   = 1'b1;
            d_served_d = 1'b1;
          end
          if (mem_ready) begin
            if (state_q == IF_BUSY) if_rdata_d = mem_rdata;
            else if (!mem_we_q)     d_rdata_d  = mem_rdata;
          end else begin
            // Aborted fetch returns all-zero, which decodes as a nop.
            if (state_q == IF_BUSY) if_rdata_d = '0;
            else                    d_rdata_d  = '0;
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_served_q <= 1'b0;
      d_served_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_served_q <= if_served_d;
      d_served_q  <= d_served_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-programmable memory model, completion scoreboard,
// and one task per scenario.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_rd, d_wr;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_done, d_done, pipe_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .pipe_stall(pipe_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { bit is_d; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [AW-1:0] addr; bit we; logic [DW-1:0] wdata; } acc_t;
  exp_t sb[$];
  acc_t log_q[$];

  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] exp_d_rdata = '0;
  int            lat = 1;
  int            wcnt = 0;
  bit            prev_req = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_we;

  // Memory model: ready on the lat-th request cycle (lat=0: never), junk data otherwise.
  always @(negedge clk) begin
    if (mem_req) begin
      if (prev_req) begin
        n_checks++;
        if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) begin
          n_fail++;
          $display("FAIL req_stable: addr %h we %b wdata %h, required %h %b %h",
                   mem_addr, mem_we, mem_wdata, prev_addr, prev_we, prev_wdata);
        end
      end
      wcnt++;
      if (lat != 0 && wcnt >= lat) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : '0;
        end
        log_q.push_back('{mem_addr, mem_we, mem_wdata});
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      wcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    prev_req   = mem_req;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  // Completion scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (if_done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL if_done_unexpected: if_rdata %h, required no completion", if_rdata);
      end else begin
        e = sb.pop_front();
        if (e.is_d || if_rdata !== e.data) begin
          n_fail++;
          $display("FAIL if_completion: if_done with if_rdata %h, required is_d=%0d data %h",
                   if_rdata, e.is_d, e.data);
        end
      end
    end
    if (d_done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL d_done_unexpected: d_rdata %h, required no completion", d_rdata);
      end else begin
        e = sb.pop_front();
        if (!e.is_d || d_rdata !== e.data) begin
          n_fail++;
          $display("FAIL d_completion: d_done with d_rdata %h, required is_d=%0d data %h",
                   d_rdata, e.is_d, e.data);
        end
      end
    end
  end

  // Samples each cycle until pipe_stall drops; stalls=-1 if it never does.
  task automatic run_txn(input int max, output int stalls, output int reqs);
    stalls = 0;
    reqs   = 0;
    for (int i = 0; i < max; i++) begin
      if (mem_req) reqs++;
      if (!pipe_stall) return;
      stalls++;
      @(negedge clk); #2;
    end
    stalls = -1;
  endtask

  task automatic drop_reqs();
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    exp_d_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_req: %b, required 0", mem_req); end
    n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: %b, required 0", pipe_stall); end
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: %b, required 0", err); end
    n_checks++; if ({if_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: %b, required 00", {if_done, d_done}); end
    n_checks++; if (if_rdata !== '0 || d_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: %h %h, required 0 0", if_rdata, d_rdata); end
    n_checks++; if (mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_bus: %h %b %h, required 0", mem_addr, mem_we, mem_wdata); end
  endtask

  task automatic test_fetch(input logic [AW-1:0] a, input logic [DW-1:0] data,
                            input int l, input int exp_st);
    int st, rq;
    mem_arr[a] = data;
    lat = l;
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = a;
    sb.push_back('{1'b0, data});
    #1;
    run_txn(40, st, rq);
    drop_reqs();
    n_checks++; if (st !== exp_st) begin n_fail++; $display("FAIL fetch_stall_cycles: %0d, required %0d", st, exp_st); end
    n_checks++; if (rq !== l)      begin n_fail++; $display("FAIL fetch_req_cycles: %0d, required %0d", rq, l); end
  endtask

  task automatic test_both();
    int st, rq, n0;
    mem_arr[32'h100] = 32'h55;
    lat = 1;
    n0 = log_q.size();
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    d_rd = 1'b1; d_addr = 32'h100;
    sb.push_back('{1'b1, 32'h55});
    sb.push_back('{1'b0, 32'h2002000A});
    exp_d_rdata = 32'h55;
    #1;
    run_txn(40, st, rq);
    drop_reqs();
    n_checks++; if (st !== 4) begin n_fail++; $display("FAIL both_stall_cycles: %0d, required 4", st); end
    n_checks++;
    if (log_q.size() !== n0 + 2) begin
      n_fail++; $display("FAIL both_access_count: %0d, required %0d", log_q.size() - n0, 2);
    end else if (log_q[n0].addr !== 32'h100 || log_q[n0].we !== 1'b0 || log_q[n0+1].addr !== 32'h40) begin
      n_fail++; $display("FAIL both_order: first %h we %b, second %h, required 100 0, 40",
                         log_q[n0].addr, log_q[n0].we, log_q[n0+1].addr);
    end
    @(negedge clk); #2;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL both_no_regrant: mem_req %b, required 0", mem_req); end
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit both,
                            input int l, input int exp_st, input logic exp_err);
    int st, rq;
    acc_t last;
    lat = l;
    @(negedge clk); #1;
    d_wr = 1'b1; d_rd = both; d_addr = a; d_wdata = wd;
    sb.push_back('{1'b1, exp_d_rdata});
    #1;
    run_txn(40, st, rq);
    drop_reqs();
    n_checks++; if (st !== exp_st) begin n_fail++; $display("FAIL write_stall_cycles: %0d, required %0d", st, exp_st); end
    n_checks++; if (rq !== l)      begin n_fail++; $display("FAIL write_req_cycles: %0d, required %0d", rq, l); end
    last = log_q[$];
    n_checks++;
    if (last.addr !== a || last.we !== 1'b1 || last.wdata !== wd) begin
      n_fail++; $display("FAIL write_access: %h we %b %h, required %h 1 %h", last.addr, last.we, last.wdata, a, wd);
    end
    n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL write_err: %b, required %b", err, exp_err); end
  endtask

  task automatic test_timeout();
    int st, rq;
    lat = 0;
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    sb.push_back('{1'b0, 32'h0});
    #1;
    run_txn(40, st, rq);
    drop_reqs();
    n_checks++; if (st !== TO + 1) begin n_fail++; $display("FAIL timeout_stall_cycles: %0d, required %0d", st, TO + 1); end
    n_checks++; if (rq !== TO)     begin n_fail++; $display("FAIL timeout_req_cycles: %0d, required %0d", rq, TO); end
    n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL timeout_err: %b, required 1", err); end
    test_fetch(32'h40, 32'h2002000A, 1, 2);
    n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL err_sticky: %b, required 1", err); end
  endtask

  task automatic test_reset_mid();
    lat = 0;
    @(negedge clk); #1;
    d_rd = 1'b1; d_addr = 32'h100;
    @(posedge clk); #3;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_busy: mem_req %b, required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: mem_req %b, required 0", mem_req); end
    n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL mid_err_clear: %b, required 0", err); end
    drop_reqs();
    sb.delete();
    exp_d_rdata = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    test_fetch(32'h44, 32'h00000013, 2, 3);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #23;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_fetch(32'h40, 32'h2002000A, 1, 2);
    test_both();
    test_write(32'h200, 32'hDEADBEEF, 1'b0, 3, 4, 1'b0);
    test_write(32'h300, 32'h12345678, 1'b1, 1, 2, 1'b1);
    apply_reset();
    #1;
    n_checks++; if (err !== 1'b0 || d_rdata !== '0) begin n_fail++; $display("FAIL rereset: err %b d_rdata %h, required 0 0", err, d_rdata); end
    test_fetch(32'h40, 32'h2002000A, 1, 2);
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end
endmodule
